// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in/serial-out shifter with a valid/ready load port and a ser_en bit tick.
// Optional feature macro PISO_PARITY_EN appends an even-parity bit after the last data bit.
module piso_serializer #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load_valid,
  output logic              o_load_ready,
  input  logic [DATA_W-1:0] i_load_data,
  input  logic              i_msb_first,
  input  logic              i_ser_en,
  output logic              o_serial_out,
  output logic              o_serial_valid,
  output logic              o_busy,
  output logic              o_done
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DATA_W);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [DATA_W-1:0]   r_shift;
  logic [DATA_W-1:0]   w_shift_nxt;
  logic                r_msb;
  logic                w_msb_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic                r_sout;
  logic                w_sout_nxt;
  logic                r_done;
  logic                w_done_nxt;

`ifdef PISO_PARITY_EN
  // The parity bit is presented while the counter sits at DATA_W, so the frame ends one retire later.
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] PAR_CNT  = CNT_W'(DATA_W - 1);

  function automatic logic f_even_parity(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction

  logic r_par;
  logic w_par_nxt;
`else
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);
`endif

  assign o_load_ready   = (r_state == S_IDLE);
  assign o_busy         = (r_state == S_SHIFT);
  assign o_serial_valid = (r_state == S_SHIFT);
  assign o_serial_out   = r_sout;
  assign o_done         = r_done;

  // Next-state and next-output logic for the IDLE/SHIFT frame controller.
  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_msb_nxt   = r_msb;
    w_cnt_nxt   = r_cnt;
    w_sout_nxt  = r_sout;
    w_done_nxt  = 1'b0;
`ifdef PISO_PARITY_EN
    w_par_nxt   = r_par;
`endif
    case (r_state)
      S_IDLE: begin
        w_sout_nxt = 1'b0;
        if (i_load_valid) begin
          w_state_nxt = S_SHIFT;
          w_shift_nxt = i_load_data;
          w_msb_nxt   = i_msb_first;
          w_cnt_nxt   = '0;
          w_sout_nxt  = i_msb_first ? i_load_data[DATA_W-1] : i_load_data[0];
`ifdef PISO_PARITY_EN
          w_par_nxt   = f_even_parity(i_load_data);
`endif
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_SHIFT: begin
        if (i_ser_en) begin
          // Counter saturates at DATA_W; it is cleared again only on the next accept.
          w_cnt_nxt = (r_cnt == FULL_CNT) ? r_cnt : r_cnt + CNT_W'(1);
          if (r_cnt == LAST_CNT) begin
            w_state_nxt = S_IDLE;
            w_sout_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
          end
`ifdef PISO_PARITY_EN
          else if (r_cnt == PAR_CNT) begin
            w_sout_nxt = r_par;
          end
`endif
          else if (r_msb) begin
            w_shift_nxt = {r_shift[DATA_W-2:0], 1'b0};
            w_sout_nxt  = r_shift[DATA_W-2];
          end else begin
            w_shift_nxt = {1'b0, r_shift[DATA_W-1:1]};
            w_sout_nxt  = r_shift[1];
          end
        end else begin
          w_state_nxt = S_SHIFT;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_sout_nxt  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset abandons any frame in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_shift <= '0;
      r_msb   <= 1'b0;
      r_cnt   <= '0;
      r_sout  <= 1'b0;
      r_done  <= 1'b0;
`ifdef PISO_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_shift <= w_shift_nxt;
      r_msb   <= w_msb_nxt;
      r_cnt   <= w_cnt_nxt;
      r_sout  <= w_sout_nxt;
      r_done  <= w_done_nxt;
`ifdef PISO_PARITY_EN
      r_par   <= w_par_nxt;
`endif
    end
  end

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
- Parametrised parallel-in/serial-out shifter; next generation of the team's 8-bit PISO.
- Accepts a DATA_W-bit word through a valid/ready handshake and shifts it out one bit per enabled clock.
- Bit order (MSB- or LSB-first) is selectable per word; a bit-rate enable (ser_en) lets it sit behind a baud or prescaler tick.
- Feeds serial links (UART-like TX, SPI MOSI) in the shift-register library.

Parameters:
- DATA_W, 8: word width in bits; legal range 2..64.
- CNT_W, $clog2(DATA_W+1): bit-counter width; localparam, not overridable.

Ports:
- clk  input  1  clock; all state on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- load_valid  input  1  producer has a word on load_data.
- load_ready  output  1  block can accept a word; high only in IDLE.
- load_data  input  DATA_W  parallel word, sampled on the accept edge.
- msb_first  input  1  bit order, sampled on the accept edge: 1 = MSB first, 0 = LSB first.
- ser_en  input  1  shift tick; the current bit advances only on edges where ser_en=1.
- serial_out  output  1  current serial bit; 0 when idle.
- serial_valid  output  1  serial_out carries a frame bit.
- busy  output  1  frame in progress.
- done  output  1  one-cycle pulse after the last bit of a frame retires.

Behaviour:
- Reset (asynchronous, any time, including mid-frame):
  - Outputs: load_ready=1, serial_out=0, serial_valid=0, busy=0, done=0.
  - Internal: shift register and bit counter cleared, state=IDLE.
  - A frame in progress is abandoned; there is no partial resume.
- States: IDLE and SHIFT.
- IDLE:
  - load_ready=1, busy=0, serial_valid=0, serial_out=0.
  - Accept edge (E0) = rising edge with load_valid=1 && load_ready=1.
  - On E0: latch load_data and msb_first; go to SHIFT.
  - Also on E0: serial_out becomes the first bit (load_data[DATA_W-1] if MSB-first, else load_data[0]); serial_valid=1, busy=1, load_ready=0, counter=0.
- SHIFT:
  - Each edge with ser_en=1 retires the current bit and increments the counter.
  - If the retired bit is not the last, the next bit is presented: next lower index for MSB-first, next higher index for LSB-first.
  - Edges with ser_en=0 hold serial_out, the counter and all state unchanged.
  - The edge retiring bit DATA_W-1 of the frame returns to IDLE. After that edge: serial_valid=0, serial_out=0, busy=0, load_ready=1, done=1 for exactly one cycle.
- Latency with ser_en held at 1:
  - Bit k is on serial_out during the cycle after edge E0+k.
  - done is high during the cycle after edge E0+DATA_W.
  - Frame occupancy is DATA_W cycles.
- Ignored inputs: load_valid while busy is ignored, and the word is not queued. msb_first and load_data changes during SHIFT have no effect.
- Back-to-back frames:
  - load_ready is high in the done cycle, so a word offered then is accepted at the next edge.
  - done drops at that same edge as the new frame starts; zero idle cycles between frames.
- ser_en during IDLE is ignored. ser_en is not required on E0.
- The counter never wraps within a frame; it saturates at DATA_W and clears on the next accept.

Optional Feature:
- Macro: PISO_PARITY_EN.
- Defined:
  - An even-parity bit (XOR of the latched word) is appended after the last data bit, as one extra SHIFT bit with serial_valid=1.
  - It is presented on the ser_en edge that retires data bit DATA_W-1.
  - done fires after the parity bit is retired; the frame is DATA_W+1 bits.
  - Bit order does not affect the parity value.
- Undefined: the frame is exactly DATA_W bits; no parity logic is instantiated.

Test Plan:
- Reset: assert rst mid-sim with random inputs -> immediately load_ready=1, serial_valid=0, serial_out=0, busy=0, done=0.
- MSB-first, DATA_W=8, ser_en=1: load 0xB2 with msb_first=1 -> serial_out 1,0,1,1,0,0,1,0 on 8 consecutive cycles; done=1 on the 9th cycle after accept; load_ready=1 again.
- LSB-first: load 0xB2 with msb_first=0 -> 0,1,0,0,1,1,0,1; msb_first toggled mid-frame has no effect.
- ser_en gating: ser_en=1 every 4th cycle, load 0xF0 MSB-first -> each bit held 4 cycles; done after 8 ser_en pulses; second load_valid pulse during the frame is ignored (load_ready=0).
- Back-to-back plus reset: load 0xFF, then assert load_valid in the done cycle with 0x00 -> 0x00 frame starts with no idle gap. Assert rst after 3 bits -> outputs return to reset values; next load 0x81 shifts out cleanly.
- PISO_PARITY_EN defined: load 0x07 -> 8 data bits then parity bit 1; load 0x03 -> parity 0; done after the 9th bit.
